// File: rtl/seg_scan_mux_n_if.sv
// Display-side bundle for seg_scan_mux_n: numeric inputs from the datapath, anode/segment drive to the pins.
// No handshake: inputs are sampled only at frame boundaries, outputs are free-running.
interface seg_scan_mux_n_if #(
   parameter int N_DIGITS = 4
);
   logic [4*N_DIGITS-1:0] digits;
   logic [N_DIGITS-1:0]   dp;
   logic [N_DIGITS-1:0]   blank;
   logic                  lzb;
   logic [3:0]            bright;
   logic [N_DIGITS-1:0]   an;
   logic [6:0]            seg;
   logic                  dp_n;
   logic                  frame_tick;

   modport master (
      output digits, dp, blank, lzb, bright,
      input  an, seg, dp_n, frame_tick
   );

   modport slave (
      input  digits, dp, blank, lzb, bright,
      output an, seg, dp_n, frame_tick
   );
endinterface

// File: rtl/seg_scan_mux_n.sv
// Multiplexed common-anode 7-segment scanner with hex decode, dp, blanking, LZB and 16-level PWM.
// Outputs lag the scan counters by one cycle; inputs are shadowed on the last cycle of each frame, no backpressure.
module seg_scan_mux_n #(
   parameter int N_DIGITS = 4,
   parameter int SUB_DIV  = 6250
) (
   input logic            clk,
   input logic            rst_n,
   seg_scan_mux_n_if.slave bus
);
   localparam int TW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam int IW = $clog2(N_DIGITS);
   localparam logic [TW-1:0] TICK_MAX = TW'(SUB_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);

   logic [TW-1:0]         r_tick;
   logic [3:0]            r_sub;
   logic [IW-1:0]         r_idx;

   logic [4*N_DIGITS-1:0] r_digits;
   logic [N_DIGITS-1:0]   r_dp;
   logic [N_DIGITS-1:0]   r_blank;
   logic                  r_lzb;
   logic [3:0]            r_bright;

   logic [N_DIGITS-1:0]   r_an;
   logic [6:0]            r_seg;
   logic                  r_dp_n;
   logic                  r_frame_tick;

   logic                  w_tick_end;
   logic                  w_sub_end;
   logic                  w_idx_end;
   logic                  w_frame_end;
   logic [3:0]            w_nibble;
   logic [N_DIGITS-1:0]   w_lz;
   logic                  w_dark;
   logic [N_DIGITS-1:0]   w_an_lit;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_tick_end  = (r_tick == TICK_MAX);
   assign w_sub_end   = (r_sub == 4'hF);
   assign w_idx_end   = (r_idx == IDX_MAX);
   assign w_frame_end = w_tick_end & w_sub_end & w_idx_end;
   assign w_nibble    = r_digits[r_idx*4 +: 4];

   // A digit is leading-zero when it and every more significant nibble are zero; digit 0 always shows.
   always_comb begin
      logic zacc;
      zacc = 1'b1;
      w_lz = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         zacc    = zacc & (r_digits[i*4 +: 4] == 4'h0);
         w_lz[i] = r_lzb & zacc & (i != 0);
      end
   end

   always_comb begin
      w_an_lit        = '1;
      w_an_lit[r_idx] = 1'b0;
      w_dark          = r_blank[r_idx] | w_lz[r_idx] | (r_sub > r_bright);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tick       <= '0;
         r_sub        <= '0;
         r_idx        <= '0;
         r_digits     <= '0;
         r_dp         <= '0;
         r_blank      <= '0;
         r_lzb        <= 1'b0;
         r_bright     <= '0;
         r_an         <= '1;
         r_seg        <= 7'h7F;
         r_dp_n       <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         if (w_tick_end) begin
            r_tick <= '0;
            if (w_sub_end) begin
               r_sub <= '0;
               r_idx <= w_idx_end ? '0 : r_idx + IW'(1);
            end else begin
               r_sub <= r_sub + 4'd1;
            end
         end else begin
            r_tick <= r_tick + TW'(1);
         end

         if (w_frame_end) begin
            r_digits <= bus.digits;
            r_dp     <= bus.dp;
            r_blank  <= bus.blank;
            r_lzb    <= bus.lzb;
            r_bright <= bus.bright;
         end
         r_frame_tick <= w_frame_end;

         if (w_dark) begin
            r_an   <= '1;
            r_seg  <= 7'h7F;
            r_dp_n <= 1'b1;
         end else begin
            r_an   <= w_an_lit;
            r_seg  <= ~hex7(w_nibble);
            r_dp_n <= ~r_dp[r_idx];
         end
      end
   end

   assign bus.an         = r_an;
   assign bus.seg        = r_seg;
   assign bus.dp_n       = r_dp_n;
   assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_mux_n.sv
// Randomised bench for seg_scan_mux_n (4 digits, 2-cycle sub-phase) against a frame-position reference model.
module tb_seg_scan_mux_n;
   localparam int ND    = 4;
   localparam int SD    = 2;
   localparam int SLOT  = 16 * SD;
   localparam int FRAME = ND * SLOT;
   localparam int NCYC  = 7000;

   logic clk;
   logic rst_n;

   seg_scan_mux_n_if #(.N_DIGITS(ND)) bus ();

   seg_scan_mux_n #(.N_DIGITS(ND), .SUB_DIV(SD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference state: position within the frame plus the shadowed inputs.
   int         pos;
   logic [15:0] sh_dig;
   logic [3:0]  sh_dp, sh_blank, sh_bright;
   logic        sh_lzb;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp_n, exp_ft;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_step();
      int idx, sub;
      logic [3:0] nib;
      logic lz, dark;
      if (!rst_n) begin
         pos = 0;
         sh_dig = '0; sh_dp = '0; sh_blank = '0; sh_lzb = 1'b0; sh_bright = '0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp_n = 1'b1; exp_ft = 1'b0;
      end else begin
         idx  = pos / SLOT;
         sub  = (pos / SD) % 16;
         nib  = 4'((sh_dig >> (4 * idx)) & 16'hF);
         lz   = sh_lzb && idx >= 1 && ((sh_dig >> (4 * idx)) == 0);
         dark = sh_blank[idx] || lz || (sub > int'(sh_bright));
         if (dark) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp_n = 1'b1;
         end else begin
            exp_an = 4'hF & ~(4'h1 << idx);
            exp_seg = ~hex_tab[nib];
            exp_dp_n = ~sh_dp[idx];
         end
         exp_ft = (pos == FRAME - 1);
         if (pos == FRAME - 1) begin
            sh_dig = bus.digits; sh_dp = bus.dp; sh_blank = bus.blank;
            sh_lzb = bus.lzb; sh_bright = bus.bright;
         end
         pos = (pos + 1) % FRAME;
      end
   endtask

   task automatic new_config();
      int keep;
      keep = $urandom_range(0, 4);
      bus.digits = 16'($urandom & ((32'h1 << (4 * keep)) - 1));
      bus.dp     = 4'($urandom);
      bus.blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom & $urandom) : 4'h0;
      bus.lzb    = 1'($urandom);
      case ($urandom_range(0, 3))
         0:       bus.bright = 4'hF;
         1:       bus.bright = 4'h0;
         default: bus.bright = 4'($urandom);
      endcase
   endtask

   initial begin
      int phase_left;
      int rst_left;
      rst_n = 1'b0;
      bus.digits = 16'h1234; bus.dp = '0; bus.blank = '0; bus.lzb = 1'b0; bus.bright = 4'hF;
      phase_left = 0;
      rst_left = 0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         if (c > 0) begin
            check("an", 32'(bus.an), 32'(exp_an), c);
            check("seg", 32'(bus.seg), 32'(exp_seg), c);
            check("dp_n", 32'(bus.dp_n), 32'(exp_dp_n), c);
            check("frame_tick", 32'(bus.frame_tick), 32'(exp_ft), c);
         end
         if (c < 3) begin
            rst_n = 1'b0;
         end else if (c < 500) begin
            // Directed opening: 1234 at full brightness, swapped to ABCD mid-frame.
            rst_n = 1'b1;
            if (c == 200) bus.digits = 16'hABCD;
            if (c == 350) begin
               bus.digits = 16'h0040; bus.dp = 4'b1000; bus.lzb = 1'b1; bus.bright = 4'd3;
            end
         end else begin
            if (rst_left > 0) begin
               rst_n = 1'b0;
               rst_left--;
            end else begin
               rst_n = 1'b1;
               if ($urandom_range(0, 1499) == 0) begin
                  rst_n = 1'b0;
                  rst_left = $urandom_range(0, 2);
               end
            end
            if (phase_left == 0) begin
               new_config();
               phase_left = $urandom_range(150, 500);
            end else begin
               phase_left--;
               if ($urandom_range(0, 299) == 0) bus.digits = 16'($urandom);
            end
         end
         model_step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
